// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - programmable interval timer sequencing a counter instance
// Optional pause input when INTERVAL_TIMER_PAUSE_EN is defined.

module counter #(
  parameter int Width = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             go,
  output logic [Width-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (go) begin
      count <= count + 1'b1;
    end
  end

endmodule

module interval_timer_ctrl #(
  parameter int Width         = 32,
  parameter int PrescaleWidth = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     periodic,
  input  logic [Width-1:0]         limit,
  input  logic [PrescaleWidth-1:0] prescale,
`ifdef INTERVAL_TIMER_PAUSE_EN
  input  logic                     pause,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     tick,
  output logic [Width-1:0]         count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [PrescaleWidth-1:0] psc;
  logic [PrescaleWidth-1:0] prescale_l;
  logic [Width-1:0]         limit_l;
  logic                     periodic_l;

  logic advance;
  logic pevent;
  logic expiry;
  logic cnt_go;
  logic cnt_clear;

`ifdef INTERVAL_TIMER_PAUSE_EN
  assign advance = !pause;
`else
  assign advance = 1'b1;
`endif

  assign pevent = (state == RUN) && advance && (psc == prescale_l);
  assign expiry = pevent && (count == limit_l);
  assign cnt_go = pevent && !expiry && !stop;

  // Count sits at zero in IDLE and is cleared on every transition into a fresh interval.
  always_comb begin
    cnt_clear = 1'b0;
    case (state)
      IDLE:    cnt_clear = 1'b1;
      RUN:     cnt_clear = stop || (expiry && periodic_l);
      DONE:    cnt_clear = start || stop;
      default: cnt_clear = 1'b1;
    endcase
  end

  counter #(.Width(Width)) u_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .go    (cnt_go),
    .count (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      tick       <= 1'b0;
      psc        <= '0;
      prescale_l <= '0;
      limit_l    <= '0;
      periodic_l <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            limit_l    <= limit;
            prescale_l <= prescale;
            periodic_l <= periodic;
            psc        <= '0;
            state      <= RUN;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            psc   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (advance) begin
            if (psc == prescale_l) begin
              psc <= '0;
              if (count == limit_l) begin
                tick <= 1'b1;
                if (!periodic_l) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end else begin
              psc <= psc + 1'b1;
            end
          end
        end
        DONE: begin
          if (stop) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            limit_l    <= limit;
            prescale_l <= prescale;
            periodic_l <= periodic;
            psc        <= '0;
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          psc   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - directed self-checking bench for interval_timer_ctrl
// Exercises the pause input when INTERVAL_TIMER_PAUSE_EN is defined.

module tb_interval_timer_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic        periodic;
  logic [31:0] limit;
  logic [7:0]  prescale;
  logic        pause;
  logic        busy;
  logic        done;
  logic        tick;
  logic [31:0] count;

  int errors = 0;
  int checks = 0;

  interval_timer_ctrl #(.Width(32), .PrescaleWidth(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .limit    (limit),
    .prescale (prescale),
`ifdef INTERVAL_TIMER_PAUSE_EN
    .pause    (pause),
`endif
    .busy     (busy),
    .done     (done),
    .tick     (tick),
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic arm(input logic [31:0] lim, input logic [7:0] psc, input logic per);
    limit    = lim;
    prescale = psc;
    periodic = per;
    start    = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    limit = '0; prescale = '0; pause = 1'b0;
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_count", count, 32'd0);
    reset = 1'b1;
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // One-shot limit=3; start held over extra edges must not restart the run
    arm(32'd3, 8'd0, 1'b0);
    step();
    check("os_busy_e0", {31'd0, busy}, 32'd1);
    check("os_count_e0", count, 32'd0);
    step();
    check("os_count_e1", count, 32'd1);
    step();
    check("os_count_e2", count, 32'd2);
    start = 1'b0;
    step();
    check("os_count_e3", count, 32'd3);
    check("os_tick_e3", {31'd0, tick}, 32'd0);
    step();
    check("os_tick_e4", {31'd0, tick}, 32'd1);
    check("os_done_e4", {31'd0, done}, 32'd1);
    check("os_busy_e4", {31'd0, busy}, 32'd0);
    check("os_count_e4", count, 32'd3);
    step();
    check("os_tick_e5", {31'd0, tick}, 32'd0);
    check("os_done_e5", {31'd0, done}, 32'd1);
    check("os_count_e5", count, 32'd3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("done_stop_done", {31'd0, done}, 32'd0);
    check("done_stop_count", count, 32'd0);

    // Periodic limit=1 prescale=2; input changes mid-run must be ignored
    arm(32'd1, 8'd2, 1'b1);
    step();
    start = 1'b0;
    limit = 32'd7; prescale = 8'd0; periodic = 1'b0;
    check("per_busy_e0", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("per_count_e%0d", k), count, (k / 3) % 2);
      check($sformatf("per_tick_e%0d", k), {31'd0, tick}, (k % 6 == 0) ? 32'd1 : 32'd0);
    end
    check("per_busy_e12", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("per_stop_busy", {31'd0, busy}, 32'd0);
    check("per_stop_count", count, 32'd0);

    // limit=0 prescale=0 periodic: tick every cycle, then stop
    arm(32'd0, 8'd0, 1'b1);
    step();
    start = 1'b0;
    check("l0_tick_e0", {31'd0, tick}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("l0_tick_e%0d", k), {31'd0, tick}, 32'd1);
      check($sformatf("l0_count_e%0d", k), count, 32'd0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("l0_stop_busy", {31'd0, busy}, 32'd0);
    check("l0_stop_tick", {31'd0, tick}, 32'd0);

    // start and stop together in IDLE stay in IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_idle_busy", {31'd0, busy}, 32'd0);

    // Stop coinciding with the expiry edge
    arm(32'd2, 8'd0, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    check("se_count_e2", count, 32'd2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("se_tick", {31'd0, tick}, 32'd0);
    check("se_busy", {31'd0, busy}, 32'd0);
    check("se_done", {31'd0, done}, 32'd0);
    check("se_count", count, 32'd0);

    // Asynchronous reset mid-run at count=5
    arm(32'd9, 8'd0, 1'b0);
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    check("ar_count_pre", count, 32'd5);
    #2 reset = 1'b0;
    #1;
    check("ar_count", count, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_tick", {31'd0, tick}, 32'd0);
    #2 reset = 1'b1;
    arm(32'd1, 8'd0, 1'b0);
    step();
    start = 1'b0;
    check("ar_busy_e0", {31'd0, busy}, 32'd1);
    step();
    check("ar_tick_e1", {31'd0, tick}, 32'd0);
    step();
    check("ar_tick_e2", {31'd0, tick}, 32'd1);
    check("ar_done_e2", {31'd0, done}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;

`ifdef INTERVAL_TIMER_PAUSE_EN
    // Pause for 3 cycles at count=1: tick moves from edge 4 to edge 7
    arm(32'd3, 8'd0, 1'b0);
    step();
    start = 1'b0;
    step();
    check("pz_count_e1", count, 32'd1);
    pause = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      step();
      check($sformatf("pz_count_e%0d", k), count, 32'd1);
      check($sformatf("pz_busy_e%0d", k), {31'd0, busy}, 32'd1);
    end
    pause = 1'b0;
    step();
    check("pz_count_e5", count, 32'd2);
    step();
    check("pz_count_e6", count, 32'd3);
    check("pz_tick_e6", {31'd0, tick}, 32'd0);
    step();
    check("pz_tick_e7", {31'd0, tick}, 32'd1);
    check("pz_done_e7", {31'd0, done}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
- Controller that sequences a `counter` instance (internal `go`/`reset` drive) as a programmable interval timer.
- A prescaler divides the clock. The counter advances once per prescaled tick and is compared against a latched limit.
- On expiry the block pulses `tick`, then either stops (one-shot) or reloads (periodic).
- Sits between a control register block and an interrupt/event aggregator.

Parameters:
- Width, 32, width of the interval counter and of `limit`/`count`.
- PrescaleWidth, 8, width of the prescaler and of `prescale`.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset: 0 clears everything immediately.
- start  input  1  level sampled each edge; arms the timer from IDLE or DONE.
- stop  input  1  level sampled each edge; aborts a running timer.
- periodic  input  1  mode select, latched at start: 1 = periodic, 0 = one-shot.
- limit  input  Width  terminal count, latched at start.
- prescale  input  PrescaleWidth  divider value, latched at start. Counter advances every prescale+1 clocks.
- busy  output  1  1 while in RUN.
- done  output  1  1 while in DONE (one-shot expired).
- tick  output  1  registered one-cycle pulse per expiry.
- count  output  Width  current counter value.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, tick=0, count=0.
  - Prescaler=0; latched limit/prescale/periodic=0.
  - The counter's reset is driven from this reset or from the internal clear.
- States are IDLE, RUN and DONE. busy = (state==RUN); done = (state==DONE).
- IDLE:
  - count held at 0.
  - start=1 latches limit, prescale and periodic, clears the prescaler, and enters RUN on the next edge.
- RUN:
  - Prescaler increments each edge.
  - When prescaler==prescale_l:
    - prescaler returns to 0 (prescaled event).
    - If count!=limit_l, `go` is asserted and count increments by 1.
    - If count==limit_l, this is an expiry: tick=1 for exactly the following cycle.
  - On expiry with periodic_l=1: count and prescaler clear to 0 and the block stays in RUN (no dead cycle).
  - On expiry with periodic_l=0: enter DONE with count held at limit_l.
- Period from RUN entry to the first tick is (limit_l+1)*(prescale_l+1) clocks. Periodic ticks then repeat at that same spacing.
- limit=0: expiry on every prescaled event, count stays 0. prescale=0: a prescaled event occurs every clock.
- DONE:
  - count holds, tick=0.
  - start=1 re-latches the inputs and enters RUN with count=0.
  - stop=1 enters IDLE with count=0.
- stop in RUN: enter IDLE, count=0, prescaler=0, no tick, even if expiry coincides with that edge.
- Priority: stop beats expiry, and expiry beats everything else.
- start in RUN is ignored; it does not restart the timer.
- start and stop together: stop wins in RUN and DONE; in IDLE, both together leave the block in IDLE.
- Changes to limit, prescale or periodic while in RUN have no effect until the next start.
- No arithmetic overflow:
  - count never exceeds limit_l; at limit=2^Width-1 the expiry occurs at all-ones with no wrap.
  - The prescaler compares against prescale_l, so it never wraps past it.
- Reset asserted mid-operation returns the block to reset values immediately. After reset release, the block waits in IDLE for start.

Optional Feature:
- Macro: INTERVAL_TIMER_PAUSE_EN.
- When defined:
  - An extra input `pause` (1 bit) is added.
  - While pause=1 in RUN, the prescaler and count freeze, and no prescaled event or expiry occurs.
  - stop still takes effect; busy stays 1.
  - Releasing pause resumes from the frozen values, so the total period is extended by exactly the paused cycles.
- When not defined: no `pause` port, and the timer always advances in RUN.

Test Plan:
- One-shot: limit=3, prescale=0, periodic=0; start pulse at edge 0.
  - busy=1 after edge 0; count steps 0,1,2,3.
  - tick=1 for one cycle after edge 4.
  - done=1 and count=3 held thereafter.
- Periodic with prescale: limit=1, prescale=2, periodic=1.
  - tick pulses every 6 clocks; count toggles 0/1 every 3 clocks.
  - Continues indefinitely with no gap cycle.
- Boundary: limit=0, prescale=0, periodic=1 gives tick=1 every cycle with count=0. stop then drops busy and tick on the next edge.
- Stop at expiry: limit=2, prescale=0, one-shot; stop=1 on the expiry edge gives no tick, state IDLE, count=0, done=0.
- Async reset: reset=0 mid-RUN with count=5 clears count, busy and tick immediately, before the next edge. After release, start with limit=1 gives a tick 2 clocks after RUN entry.
- With INTERVAL_TIMER_PAUSE_EN: limit=3, prescale=0; pause=1 for 3 cycles while count=1. The count freezes at 1 and the tick arrives 7 clocks after RUN entry instead of 4.
